// File: rtl/vc_sched_pkg.sv
// rtl/vc_sched_pkg.sv - shared sizing, state type and pointer helper for the VC commit scheduler
package vc_sched_pkg;

    localparam int NUM_VC      = 4;
    localparam int BUFFER_SIZE = 8;
    localparam int CREDIT_MAX  = 4;

    localparam int VC_W   = $clog2(NUM_VC);
    localparam int OCC_W  = $clog2(BUFFER_SIZE) + 1;
    localparam int CRED_W = $clog2(CREDIT_MAX) + 1;
    // Wide enough to hold the sum of all per-VC occupancies.
    localparam int SUM_W  = OCC_W + VC_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } sched_state_e;

    // NUM_VC is a power of two, so the wrap falls out of the VC_W-bit add.
    function automatic logic [VC_W-1:0] next_vc(input logic [VC_W-1:0] ptr);
        return ptr + VC_W'(1);
    endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// rtl/vc_rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr
//   req_i   : per-VC request vector
//   ptr_i   : round-robin start position
//   grant_o : one-hot grant (zero when no request)
//   idx_o   : encoded grant index (zero when no request)
module vc_rr_arbiter
    import vc_sched_pkg::*;
(
    input  logic [NUM_VC-1:0] req_i,
    input  logic [VC_W-1:0]   ptr_i,
    output logic [NUM_VC-1:0] grant_o,
    output logic [VC_W-1:0]   idx_o
);

    logic [2*NUM_VC-1:0] req_dbl;
    logic [2*NUM_VC-1:0] masked;
    logic                found;

    // Requests are duplicated so that masking off everything below ptr in the
    // lower copy still leaves the wrapped-around requesters visible in the
    // upper copy; a plain lowest-bit priority then yields round-robin order.
    always_comb begin
        req_dbl = {req_i, req_i};
        masked  = req_dbl & ({(2*NUM_VC){1'b1}} << ptr_i);
        found   = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < 2*NUM_VC; i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                idx_o = VC_W'(i % NUM_VC);
            end
        end
        grant_o = found ? (NUM_VC'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/vc_commit_scheduler.sv
// rtl/vc_commit_scheduler.sv - per-VC occupancy/credit tracking, round-robin commit and output register
//   clk, rst                 : clock, synchronous active-high reset
//   enq_fire, enq_vc         : enqueue accepted by the shared buffer and its VC
//   commit_ready, commit_id  : pop strobe and VC toward the buffer
//   buf_valid, buf_data      : buffer's response for the popped head word
//   out_valid/out_data/out_vc, out_ready : registered output stage toward the link
//   credit_ret               : per-VC downstream credit returns
//   err                      : sticky protocol error
module vc_commit_scheduler
    import vc_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_fire,
    input  logic [VC_W-1:0]   enq_vc,
    output logic              commit_ready,
    output logic [VC_W-1:0]   commit_id,
    input  logic              buf_valid,
    input  logic [31:0]       buf_data,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic [VC_W-1:0]   out_vc,
    input  logic              out_ready,
    input  logic [NUM_VC-1:0] credit_ret,
    output logic              err
);

    logic [OCC_W-1:0]  occ_q  [NUM_VC];
    logic [OCC_W-1:0]  occ_d  [NUM_VC];
    logic [CRED_W-1:0] cred_q [NUM_VC];
    logic [CRED_W-1:0] cred_d [NUM_VC];
    logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [VC_W-1:0]   last_id_q, last_id_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [VC_W-1:0]   out_vc_q, out_vc_d;
    logic              err_q, err_d;
    sched_state_e      state_q, state_d;

    logic [NUM_VC-1:0] eligible, grant, inc_v, dec_v, cred_full;
    logic [VC_W-1:0]   grant_idx;
    logic [SUM_W-1:0]  occ_sum;
    logic              any_elig, slot_free, commit, buf_full;

    always_comb begin
        occ_sum = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            eligible[v]  = (occ_q[v] != '0) && (cred_q[v] != '0);
            cred_full[v] = (cred_q[v] == CRED_W'(CREDIT_MAX));
            occ_sum      = occ_sum + SUM_W'(occ_q[v]);
        end
    end

    assign any_elig  = |eligible;
    assign slot_free = !out_valid_q || out_ready;
    assign commit    = slot_free && any_elig;
    assign buf_full  = (occ_sum == SUM_W'(BUFFER_SIZE));

    vc_rr_arbiter u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    assign commit_ready = commit;
    assign commit_id    = commit ? grant_idx : last_id_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_vc       = out_vc_q;
    assign err          = err_q;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            // An enqueue into a full buffer is an error and is not counted,
            // keeping the per-VC counters within their range.
            inc_v[v] = enq_fire && !buf_full && (enq_vc == VC_W'(v));
            dec_v[v] = commit && grant[v];

            occ_d[v] = occ_q[v];
            if (inc_v[v] && !dec_v[v]) begin
                occ_d[v] = occ_q[v] + OCC_W'(1);
            end else if (dec_v[v] && !inc_v[v]) begin
                occ_d[v] = occ_q[v] - OCC_W'(1);
            end

            // A return at CREDIT_MAX saturates rather than wrapping.
            cred_d[v] = cred_q[v];
            if (dec_v[v] && !credit_ret[v]) begin
                cred_d[v] = cred_q[v] - CRED_W'(1);
            end else if (credit_ret[v] && !dec_v[v] && !cred_full[v]) begin
                cred_d[v] = cred_q[v] + CRED_W'(1);
            end
        end

        rr_ptr_d    = commit ? next_vc(grant_idx) : rr_ptr_q;
        last_id_d   = commit ? grant_idx : last_id_q;
        out_valid_d = commit ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_data_d  = commit ? buf_data : out_data_q;
        out_vc_d    = commit ? grant_idx : out_vc_q;

        err_d = err_q
              | (enq_fire && buf_full)
              | (|(credit_ret & cred_full))
              | (buf_valid != commit);
    end

    // The status is derived fresh every cycle; no state carries history, so
    // every state takes the same transitions.
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE, ACTIVE, STALL: begin
                if (commit) begin
                    state_d = ACTIVE;
                end else if (any_elig) begin
                    state_d = STALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                occ_q[v]  <= '0;
                cred_q[v] <= CRED_W'(CREDIT_MAX);
            end
            rr_ptr_q    <= '0;
            last_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_vc_q    <= '0;
            err_q       <= 1'b0;
            state_q     <= IDLE;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                occ_q[v]  <= occ_d[v];
                cred_q[v] <= cred_d[v];
            end
            rr_ptr_q    <= rr_ptr_d;
            last_id_q   <= last_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_vc_q    <= out_vc_d;
            err_q       <= err_d;
            state_q     <= state_d;
        end
    end

endmodule

// File: tb/tb_vc_commit_scheduler.sv
// tb/tb_vc_commit_scheduler.sv - scoreboard bench for vc_commit_scheduler
module tb_vc_commit_scheduler;
    import vc_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              enq_fire;
    logic [VC_W-1:0]   enq_vc;
    logic              commit_ready;
    logic [VC_W-1:0]   commit_id;
    logic              buf_valid;
    logic [31:0]       buf_data;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [VC_W-1:0]   out_vc;
    logic              out_ready;
    logic [NUM_VC-1:0] credit_ret;
    logic              err;
    logic              inj;

    always #5 clk = ~clk;

    vc_commit_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .enq_fire     (enq_fire),
        .enq_vc       (enq_vc),
        .commit_ready (commit_ready),
        .commit_id    (commit_id),
        .buf_valid    (buf_valid),
        .buf_data     (buf_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_vc       (out_vc),
        .out_ready    (out_ready),
        .credit_ret   (credit_ret),
        .err          (err)
    );

    // Shared buffer stand-in: per-VC FIFOs, head word presented for commit_id.
    logic [31:0] bufmem [NUM_VC][BUFFER_SIZE];
    int          bhead  [NUM_VC];
    int          btail  [NUM_VC];

    assign buf_data  = bufmem[commit_id][bhead[commit_id]];
    assign buf_valid = commit_ready ^ inj;

    // Reference model state.
    int m_occ  [NUM_VC];
    int m_cred [NUM_VC];
    int m_ptr, m_last;
    bit m_outv, m_err;

    typedef struct {
        int          vc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        for (int v = 0; v < NUM_VC; v++) s += m_occ[v];
        return s;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) begin
            m_occ[v]  = 0;
            m_cred[v] = CREDIT_MAX;
            bhead[v]  = 0;
            btail[v]  = 0;
        end
        m_ptr  = 0;
        m_last = 0;
        m_outv = 0;
        m_err  = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enq_fire   = 1'b0;
        enq_vc     = '0;
        credit_ret = '0;
        out_ready  = 1'b0;
        inj        = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_commit_ready", commit_ready, 0);
        chk("rst_commit_id", commit_id, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_vc", out_vc, 0);
    endtask

    // One clock cycle: drive inputs, predict this cycle's commit, then update the model.
    task automatic step(input bit ef, input int ev, input logic [NUM_VC-1:0] cr,
                        input bit ordy, input bit bvi);
        int          sum;
        int          v;
        bit          c;
        int          cv;
        logic [31:0] d;
        enq_fire   = ef;
        enq_vc     = VC_W'(ev);
        credit_ret = cr;
        out_ready  = ordy;
        inj        = bvi;
        d          = $urandom;
        #1;
        c  = 0;
        cv = m_last;
        if (!m_outv || ordy) begin
            for (int i = 0; i < NUM_VC; i++) begin
                v = (m_ptr + i) % NUM_VC;
                if (!c && m_occ[v] > 0 && m_cred[v] > 0) begin
                    c  = 1;
                    cv = v;
                end
            end
        end
        chk("commit_ready", commit_ready, c);
        chk("commit_id", commit_id, cv);
        chk("out_valid", out_valid, m_outv);
        chk("err", err, m_err);
        if (c) exp_q.push_back('{vc: cv, data: bufmem[cv][bhead[cv]]});
        @(posedge clk);
        #1;
        sum = model_sum();
        if (ef && sum == BUFFER_SIZE) m_err = 1;
        if (bvi) m_err = 1;
        for (int i = 0; i < NUM_VC; i++) begin
            if (cr[i] && m_cred[i] == CREDIT_MAX) m_err = 1;
            m_cred[i] = m_cred[i] - ((c && cv == i) ? 1 : 0) + (cr[i] ? 1 : 0);
            if (m_cred[i] > CREDIT_MAX) m_cred[i] = CREDIT_MAX;
        end
        if (c) begin
            m_occ[cv]--;
            bhead[cv] = (bhead[cv] + 1) % BUFFER_SIZE;
            m_ptr     = (cv + 1) % NUM_VC;
            m_last    = cv;
        end
        if (ef && sum < BUFFER_SIZE) begin
            m_occ[ev]++;
            bufmem[ev][btail[ev]] = d;
            btail[ev] = (btail[ev] + 1) % BUFFER_SIZE;
        end
        m_outv = c ? 1'b1 : (ordy ? 1'b0 : m_outv);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold stability.
    initial begin
        bit              hv;
        logic [31:0]     hd;
        logic [VC_W-1:0] hvc;
        exp_t            e;
        hv = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hv = 0;
            end else begin
                if (hv && out_valid) begin
                    chk("hold_data", out_data, hd);
                    chk("hold_vc", out_vc, 32'(hvc));
                end
                hv = 0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got vc %0d data %0h expected none", out_vc, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_vc", 32'(out_vc), e.vc);
                        chk("out_data", out_data, e.data);
                    end
                end else if (out_valid) begin
                    hv  = 1;
                    hd  = out_data;
                    hvc = out_vc;
                end
            end
        end
    end

    initial begin
        int          vcs [3];
        bit          ef;
        int          ev;
        logic [NUM_VC-1:0] cr;
        vcs = '{0, 1, 3};
        rst = 1'b1; enq_fire = 1'b0; enq_vc = '0; credit_ret = '0; out_ready = 1'b0; inj = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single word to VC2.
        step(1, 2, '0, 1, 0);
        repeat (4) step(0, 0, '0, 1, 0);

        // Two words each to VC0, VC1, VC3, then drain.
        do_reset();
        for (int k = 0; k < 6; k++) step(1, vcs[k % 3], '0, 0, 0);
        repeat (10) step(0, 0, '0, 1, 0);

        // Credit exhaustion on VC1, then a single credit return.
        do_reset();
        repeat (5) step(1, 1, '0, 1, 0);
        repeat (6) step(0, 0, '0, 1, 0);
        step(0, 0, 4'b0010, 1, 0);
        repeat (4) step(0, 0, '0, 1, 0);

        // Back-pressure hold then release.
        do_reset();
        repeat (3) step(1, 0, '0, 0, 0);
        repeat (10) step(0, 0, '0, 0, 0);
        repeat (5) step(0, 0, '0, 1, 0);

        // Same-cycle enqueue and commit on VC3, then credit return at max.
        do_reset();
        step(1, 3, '0, 1, 0);
        step(1, 3, '0, 1, 0);
        repeat (3) step(0, 0, '0, 1, 0);
        step(0, 0, 4'b0001, 1, 0);
        repeat (2) step(0, 0, '0, 1, 0);
        repeat (5) step(1, 0, '0, 1, 0);
        repeat (6) step(0, 0, '0, 1, 0);

        // Enqueue into a full buffer.
        do_reset();
        repeat (10) step(1, 0, '0, 0, 0);
        repeat (3) step(0, 0, '0, 0, 0);

        // buf_valid disagreeing with commit_ready.
        do_reset();
        step(0, 0, '0, 1, 1);
        repeat (2) step(0, 0, '0, 1, 0);

        // Reset while a word is held.
        do_reset();
        step(1, 2, '0, 0, 0);
        repeat (2) step(0, 0, '0, 0, 0);
        do_reset();
        repeat (2) step(0, 0, '0, 1, 0);

        // Randomized legal traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ef = (model_sum() < BUFFER_SIZE) && ($urandom_range(0, 1) == 1);
            ev = $urandom_range(0, NUM_VC - 1);
            cr = '0;
            for (int v = 0; v < NUM_VC; v++) begin
                if (m_cred[v] < CREDIT_MAX && $urandom_range(0, 2) == 0) cr[v] = 1'b1;
            end
            step(ef, ev, cr, $urandom_range(0, 9) < 7, 0);
        end
        repeat (4) step(0, 0, '0, 1, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
